sigma_core_memory: RTL and testbench



---
 rtl/sigma_core_memory_if.sv | 23 ++
 rtl/sigma_core_memory.sv | 123 ++++++++++++
 tb/tb_sigma_core_memory.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sigma_core_memory_if.sv
// Request/response bundle between the CPU memory port and the core-memory responder.
// Bit numbering is big-endian throughout: bit 0 is the MSB, byte 0 is bits 0:7.
interface sigma_core_memory_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [15:31] req_addr;
  logic [0:31]  req_wdata;
  logic [0:3]   req_bytemask;
  logic         rsp_valid;
  logic [0:31]  rsp_rdata;
  logic         rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_bytemask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_bytemask,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/sigma_core_memory.sv
// Core-memory responder: one access at a time with ACCESS / RESPOND / RECOVER timing.
// Every access returns the word's prior contents; in-range writes merge bytes on leaving RESPOND.
module sigma_core_memory #(
  parameter int DEPTH          = 4096,
  parameter int ACCESS_CYCLES  = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input logic                clock,
  input logic                reset,
  sigma_core_memory_if.slave bus
);
  localparam int          AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  ACCESS_LOAD  = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0]  RECOVER_LOAD = 8'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);
  localparam logic [17:0] DEPTH_LIMIT  = 18'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RECOVER} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [16:0] addr_q, addr_d;
  logic [0:31] wdata_q, wdata_d;
  logic [0:3]  mask_q, mask_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [0:31] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic [0:31]   mem [DEPTH];
  logic [0:31]   mem_rd_q;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          commit;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIMIT);
  assign mem_idx  = addr_q[AW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    commit      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          mask_d  = bus.req_bytemask;
          cnt_d   = ACCESS_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) state_d = RESPOND;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RESPOND: begin
        // The response register loads on the edge that leaves RESPOND, alongside the commit.
        rsp_valid_d = 1'b1;
        rsp_rdata_d = in_range ? mem_rd_q : '0;
        rsp_error_d = !in_range;
        commit      = write_q && in_range;
        if (RECOVER_CYCLES > 0) begin
          state_d = RECOVER;
          cnt_d   = RECOVER_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      RECOVER: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Read-first array port: mem_rd_q settles during ACCESS, so RESPOND always sees the prior word.
  always_ff @(posedge clock) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
    mem_rd_q <= mem[mem_idx];
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
endmodule

// File: tb/tb_sigma_core_memory.sv
// Bench for sigma_core_memory: two instances (3/2 and 1/0 timing) checked every cycle
// against a transaction-level model of ready windows, response timing and memory contents.
module tb_sigma_core_memory;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_write [2];
  logic [16:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [0:3]  req_mask  [2];
  logic        o_ready   [2];
  logic        o_valid   [2];
  logic        o_err     [2];
  logic [31:0] o_rdata   [2];

  sigma_core_memory_if bus_a ();
  sigma_core_memory_if bus_b ();

  assign bus_a.req_valid    = req_valid[0];
  assign bus_a.req_write    = req_write[0];
  assign bus_a.req_addr     = req_addr[0];
  assign bus_a.req_wdata    = req_wdata[0];
  assign bus_a.req_bytemask = req_mask[0];
  assign o_ready[0]         = bus_a.req_ready;
  assign o_valid[0]         = bus_a.rsp_valid;
  assign o_rdata[0]         = bus_a.rsp_rdata;
  assign o_err[0]           = bus_a.rsp_error;

  assign bus_b.req_valid    = req_valid[1];
  assign bus_b.req_write    = req_write[1];
  assign bus_b.req_addr     = req_addr[1];
  assign bus_b.req_wdata    = req_wdata[1];
  assign bus_b.req_bytemask = req_mask[1];
  assign o_ready[1]         = bus_b.req_ready;
  assign o_valid[1]         = bus_b.rsp_valid;
  assign o_rdata[1]         = bus_b.rsp_rdata;
  assign o_err[1]           = bus_b.rsp_error;

  sigma_core_memory #(.DEPTH(4096), .ACCESS_CYCLES(3), .RECOVER_CYCLES(2)) dut_a (
    .clock(clock), .reset(rst[0]), .bus(bus_a));
  sigma_core_memory #(.DEPTH(1024), .ACCESS_CYCLES(1), .RECOVER_CYCLES(0)) dut_b (
    .clock(clock), .reset(rst[1]), .bus(bus_b));

  function automatic int acc_of(int i);   return (i == 0) ? 3 : 1;       endfunction
  function automatic int rec_of(int i);   return (i == 0) ? 2 : 0;       endfunction
  function automatic int depth_of(int i); return (i == 0) ? 4096 : 1024; endfunction

  function automatic int pool_addr(int i, int k);
    case (k)
      0: return 0;
      1: return 'h10;
      2: return 'h20;
      3: return 'h30;
      4: return 7;
      5: return depth_of(i) - 1;
      6: return depth_of(i) - 2;
      default: return 'h100;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [0:3] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[31-8*b -: 8] = n[31-8*b -: 8];
    return r;
  endfunction

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted request owns a fixed window of edges.
  int          edge_n = 0;
  int          ready_from [2];
  bit          pend       [2];
  int          pend_at    [2];
  bit          pend_w     [2];
  int          pend_addr  [2];
  logic [31:0] pend_data  [2];
  logic [0:3]  pend_mask  [2];
  bit          exp_valid  [2];
  logic [31:0] exp_rdata  [2];
  bit          exp_err    [2];
  bit          exp_known  [2];
  logic [31:0] mmem   [2][4096];
  bit          mknown [2][4096];
  int          acc_cnt  [2];
  int          acc_edge [2];
  int          rsp_n    [2];
  int          rsp_edge [2];
  logic [31:0] rsp_data [2];
  bit          rsp_err  [2];

  task automatic model_reset(input int i);
    pend[i]       = 1'b0;
    exp_valid[i]  = 1'b0;
    exp_rdata[i]  = '0;
    exp_err[i]    = 1'b0;
    exp_known[i]  = 1'b1;
    ready_from[i] = edge_n;
  endtask

  always @(posedge clock) begin
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 1'b0;
      if (rst[i]) begin
        model_reset(i);
      end else begin
        if (pend[i] && pend_at[i] == edge_n) begin
          pend[i]      = 1'b0;
          exp_valid[i] = 1'b1;
          if (pend_addr[i] < depth_of(i)) begin
            exp_err[i]   = 1'b0;
            exp_rdata[i] = mmem[i][pend_addr[i]];
            exp_known[i] = mknown[i][pend_addr[i]];
            if (pend_w[i]) begin
              mmem[i][pend_addr[i]] = merge(mmem[i][pend_addr[i]], pend_data[i], pend_mask[i]);
              if (pend_mask[i] == 4'b1111) mknown[i][pend_addr[i]] = 1'b1;
            end
          end else begin
            exp_err[i]   = 1'b1;
            exp_rdata[i] = '0;
            exp_known[i] = 1'b1;
          end
        end
        if (edge_n - 1 >= ready_from[i] && req_valid[i]) begin
          ready_from[i] = edge_n + acc_of(i) + 1 + rec_of(i);
          pend[i]       = 1'b1;
          pend_at[i]    = edge_n + acc_of(i) + 1;
          pend_w[i]     = req_write[i];
          pend_addr[i]  = int'(req_addr[i]);
          pend_data[i]  = req_wdata[i];
          pend_mask[i]  = req_mask[i];
          acc_cnt[i]++;
          acc_edge[i]   = edge_n;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (check_en) begin
        chk($sformatf("dut%0d_req_ready", i), 32'(o_ready[i]), 32'(edge_n >= ready_from[i]));
        chk($sformatf("dut%0d_rsp_valid", i), 32'(o_valid[i]), 32'(exp_valid[i]));
        chk($sformatf("dut%0d_rsp_error", i), 32'(o_err[i]), 32'(exp_err[i]));
        if (exp_known[i]) chk($sformatf("dut%0d_rsp_rdata", i), o_rdata[i], exp_rdata[i]);
      end
      if (o_valid[i]) begin
        rsp_n[i]++;
        rsp_edge[i] = edge_n;
        rsp_data[i] = o_rdata[i];
        rsp_err[i]  = o_err[i];
      end
    end
  end

  task automatic drive(input int i, input bit w, input int a, input logic [31:0] d, input logic [0:3] m);
    req_write[i] = w;
    req_addr[i]  = 17'(a);
    req_wdata[i] = d;
    req_mask[i]  = m;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_accept(input int i, input int n0);
    int k;
    k = 0;
    while (acc_cnt[i] == n0 && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    chk($sformatf("dut%0d_accept_in_time", i), 32'(acc_cnt[i] != n0), 32'd1);
  endtask

  task automatic xact(input int i, input bit w, input int a, input logic [31:0] d,
                      input logic [0:3] m, output logic [31:0] rd, output bit er, output int lat);
    int n0, r0, k;
    n0 = acc_cnt[i];
    r0 = rsp_n[i];
    drive(i, w, a, d, m);
    wait_accept(i, n0);
    req_valid[i] = 1'b0;
    k = 0;
    while (rsp_n[i] == r0 && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    chk($sformatf("dut%0d_response_in_time", i), 32'(rsp_n[i] != r0), 32'd1);
    rd  = rsp_data[i];
    er  = rsp_err[i];
    lat = rsp_edge[i] - acc_edge[i];
    $display("[TB] dut%0d %s addr=%05h wdata=%08h mask=%b -> rdata=%08h err=%0d lat=%0d",
             i, w ? "WR" : "RD", a, d, m, rd, er, lat);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, v, v0;
    bit er;
    int lat, e0, e1, e2, r0, n0, i, k, a;
    for (int j = 0; j < 2; j++) begin
      rst[j] = 1'b1; req_valid[j] = 1'b0; req_write[j] = 1'b0;
      req_addr[j] = '0; req_wdata[j] = '0; req_mask[j] = '0;
      ready_from[j] = 0; pend[j] = 1'b0; exp_valid[j] = 1'b0; exp_rdata[j] = '0;
      exp_err[j] = 1'b0; exp_known[j] = 1'b1; acc_cnt[j] = 0; rsp_n[j] = 0;
      for (int w = 0; w < 4096; w++) mknown[j][w] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #3;
    check_en = 1'b1;
    chk("reset_ready", 32'(o_ready[0]), 32'd1);
    chk("reset_rsp_valid", 32'(o_valid[0]), 32'd0);
    chk("reset_rsp_rdata", o_rdata[0], 32'h0);
    chk("reset_rsp_error", 32'(o_err[0]), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int j = 0; j < 2; j++)
      for (int p = 0; p < 8; p++) xact(j, 1'b1, pool_addr(j, p), $urandom, 4'b1111, rd, er, lat);

    // Basic write, read-back and byte merge
    xact(0, 1'b1, 'h10, 32'h12345678, 4'b1111, rd, er, lat);
    chk("t1_write_latency", 32'(lat), 32'd4);
    chk("t1_write_error", 32'(er), 32'd0);
    xact(0, 1'b0, 'h10, 32'h0, 4'b0000, rd, er, lat);
    chk("t1_read_back", rd, 32'h12345678);
    xact(0, 1'b1, 'h10, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    chk("t2_write_returns_prior", rd, 32'h12345678);
    xact(0, 1'b0, 'h10, 32'h0, 4'b0000, rd, er, lat);
    chk("t2_merged_read", rd, 32'h12BB56DD);

    // req_valid held through busy periods: acceptances on the first idle edge
    r0 = rsp_n[0];
    n0 = acc_cnt[0];
    drive(0, 1'b0, 'h20, 32'h0, 4'b0000);
    wait_accept(0, n0); e0 = acc_edge[0]; req_addr[0] = 17'h30;
    wait_accept(0, n0 + 1); e1 = acc_edge[0]; req_addr[0] = 17'h7;
    wait_accept(0, n0 + 2); e2 = acc_edge[0]; req_valid[0] = 1'b0;
    chk("t3_spacing_1", 32'(e1 - e0), 32'd7);
    chk("t3_spacing_2", 32'(e2 - e1), 32'd7);
    repeat (8) @(posedge clock);
    #1;
    chk("t3_three_pulses", 32'(rsp_n[0] - r0), 32'd3);

    // Out-of-range addresses error and never touch the array
    xact(0, 1'b0, 'h0, 32'h0, 4'b0000, v0, er, lat);
    xact(0, 1'b0, 'h1000, 32'h0, 4'b0000, rd, er, lat);
    chk("t4_read_oob_error", 32'(er), 32'd1);
    chk("t4_read_oob_rdata", rd, 32'h0);
    xact(0, 1'b1, 'h1000, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
    chk("t4_write_oob_error", 32'(er), 32'd1);
    xact(0, 1'b0, 'h1FFFF, 32'h0, 4'b0000, rd, er, lat);
    chk("t4_top_addr_error", 32'(er), 32'd1);
    xact(0, 1'b0, 'h0, 32'h0, 4'b0000, rd, er, lat);
    chk("t4_addr0_unchanged", rd, v0);

    // Reset during ACCESS aborts an uncommitted write
    xact(0, 1'b0, 'h20, 32'h0, 4'b0000, v, er, lat);
    n0 = acc_cnt[0];
    drive(0, 1'b1, 'h20, 32'hDEADBEEF, 4'b1111);
    wait_accept(0, n0);
    req_valid[0] = 1'b0;
    #2;
    rst[0] = 1'b1;
    model_reset(0);
    #1;
    chk("t5_ready_in_reset", 32'(o_ready[0]), 32'd1);
    chk("t5_rsp_valid_in_reset", 32'(o_valid[0]), 32'd0);
    repeat (2) @(posedge clock);
    #3;
    rst[0] = 1'b0;
    xact(0, 1'b0, 'h20, 32'h0, 4'b0000, rd, er, lat);
    chk("t5_write_not_committed", rd, v);

    // Short timing variant and an empty byte mask
    xact(1, 1'b1, 'h10, 32'h0BADF00D, 4'b1111, rd, er, lat);
    xact(1, 1'b1, 'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    chk("t6_latency", 32'(lat), 32'd2);
    chk("t6_mask0_prior", rd, 32'h0BADF00D);
    xact(1, 1'b0, 'h10, 32'h0, 4'b0000, rd, er, lat);
    chk("t6_mask0_intact", rd, 32'h0BADF00D);
    n0 = acc_cnt[1];
    drive(1, 1'b0, 'h20, 32'h0, 4'b0000);
    wait_accept(1, n0); e0 = acc_edge[1];
    wait_accept(1, n0 + 1); e1 = acc_edge[1];
    req_valid[1] = 1'b0;
    chk("t6_spacing", 32'(e1 - e0), 32'd3);
    repeat (4) @(posedge clock);
    #1;

    // Randomized traffic across both instances
    for (int n = 0; n < 60; n++) begin
      i = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      a = (k < 8) ? pool_addr(i, k) : ((k == 8) ? depth_of(i) : 'h1FFFF);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      xact(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, er, lat);
      chk($sformatf("dut%0d_rand_latency", i), 32'(lat), 32'(acc_of(i) + 1));
    end

    repeat (3) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
